// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps the PC, issues single-outstanding word reads to instruction
// memory and buffers returned words with their PC in a small FIFO for the decode stage.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [31:0]      pc_r;
  logic [31:0]      pc_s;
  logic [31:0]      req_pc_r;
  logic             req_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] space_s;
  logic [CNT_W-1:0] cnt_after_push_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      fifo_pc_r    [FIFO_DEPTH];
  logic [31:0]      fifo_instr_r [FIFO_DEPTH];
  logic             unused_s;

  assign unused_s    = ^redirect_pc[1:0];
  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = (count_r != {CNT_W{1'b0}});
  assign instruction = instr_valid ? fifo_instr_r[rd_ptr_r] : 32'h0000_0000;
  assign instr_pc    = instr_valid ? fifo_pc_r[rd_ptr_r]    : 32'h0000_0000;

  // The outstanding request reserves a slot so a response can never overflow the buffer.
  assign space_s          = DEPTH_C - count_r - CNT_W'(state_r == WAIT);
  assign pop_s            = instr_valid && instr_ready && !redirect_valid;
  assign cnt_after_push_s = count_r + CNT_W'(1) - CNT_W'(pop_s);

  // Next-state, next-PC and FIFO push decision; a redirect overrides everything.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    push_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (space_s != {CNT_W{1'b0}}) state_s = REQ;
        else                          state_s = IDLE;
      end
      REQ: begin
        if (imem_gnt) begin
          pc_s    = pc_r + 32'd4;
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push_s  = 1'b1;
          state_s = (cnt_after_push_s < DEPTH_C) ? REQ : IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (imem_rvalid) state_s = REQ;
        else             state_s = DROP;
      end
      default: state_s = IDLE;
    endcase
    if (redirect_valid) begin
      pc_s   = {redirect_pc[31:2], 2'b00};
      push_s = 1'b0;
      case (state_r)
        IDLE:    state_s = REQ;
        REQ:     state_s = imem_gnt    ? DROP : REQ;
        WAIT:    state_s = imem_rvalid ? REQ  : DROP;
        DROP:    state_s = imem_rvalid ? REQ  : DROP;
        default: state_s = IDLE;
      endcase
    end else begin
      pc_s = pc_s;
    end
  end

  // Control registers: FSM, PC, request flag and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
      req_r    <= 1'b0;
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      req_r   <= (state_s == REQ);
      if (state_r == REQ && imem_gnt) req_pc_r <= pc_r;
      if (redirect_valid) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
    end
  end

  // FIFO storage; contents are only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_r[wr_ptr_r]    <= req_pc_r;
      fifo_instr_r[wr_ptr_r] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory responder plus a decode-side scoreboard.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  logic        rv_auto = 1'b0;
  logic [31:0] raddr = 32'h0;
  logic        rvalid_man;
  logic [31:0] rdata_man;
  logic        stall_en;
  logic [31:0] stall_addr;

  logic [63:0] sb[$];
  logic [31:0] addr_log[$];
  logic [63:0] pop_log[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h0050_0093;
    else if (a == 32'h0000_0004) return 32'h00A0_0113;
    else                         return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rvalid = rv_auto | rvalid_man;
  assign imem_rdata  = rvalid_man ? rdata_man : mem_word(raddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers grants one cycle later and predicts what decode must see.
  always @(posedge clk) begin
    rv_auto <= 1'b0;
    if (rst_n && imem_req && imem_gnt) begin
      addr_log.push_back(imem_addr);
      if (!(stall_en && imem_addr == stall_addr)) begin
        rv_auto <= 1'b1;
        raddr   <= imem_addr;
      end
    end
    if (!rst_n || redirect_valid)
      sb.delete();
    else if (imem_req && imem_gnt && !(stall_en && imem_addr == stall_addr))
      sb.push_back({imem_addr, mem_word(imem_addr)});
  end

  // Decode side: every accepted instruction is compared with the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: got pc %h instr %h expected nothing", instr_pc, instruction);
      end
      if (sb.size() != 0) begin
        check("dec_pc", instr_pc, sb[0][63:32]);
        check("dec_instr", instruction, sb[0][31:0]);
        void'(sb.pop_front());
      end
      pop_log.push_back({instr_pc, instruction});
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; rvalid_man = 1'b0; rdata_man = 32'h0;
    stall_en = 1'b0; stall_addr = 32'h0;
    tick; tick;
    rst_n = 1'b1;
    addr_log.delete();
    pop_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    check({tag, "_instr"}, instruction, 32'h0);
    check({tag, "_pc"}, instr_pc, 32'h0);
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 60 && pop_log.size() < n; i++) tick;
    check("pop_timeout", {31'h0, pop_log.size() >= n}, 32'h1);
  endtask

  task automatic wait_req;
    for (int i = 0; i < 20 && !imem_req; i++) tick;
    check("req_timeout", {31'h0, imem_req}, 32'h1);
  endtask

  initial begin
    // 1: reset values, then streaming fetch with immediate grant.
    rst_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; rvalid_man = 1'b0; rdata_man = 32'h0;
    stall_en = 1'b0; stall_addr = 32'h0;
    tick; tick;
    check_reset_outputs("rst");
    rst_n = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 30 && (addr_log.size() < 3 || pop_log.size() < 2); i++) tick;
    check("t1_grants", {31'h0, addr_log.size() >= 3}, 32'h1);
    check("t1_addr0", addr_log[0], 32'h0);
    check("t1_addr1", addr_log[1], 32'h4);
    check("t1_addr2", addr_log[2], 32'h8);
    wait_pops(2);
    check("t1_pop0_pc", pop_log[0][63:32], 32'h0);
    check("t1_pop0_ins", pop_log[0][31:0], 32'h0050_0093);
    check("t1_pop1_pc", pop_log[1][63:32], 32'h4);
    check("t1_pop1_ins", pop_log[1][31:0], 32'h00A0_0113);

    // 2: decode stalled, buffer fills and fetch stops; one pop frees one slot.
    do_reset;
    imem_gnt = 1'b1;
    repeat (12) tick;
    check("t2_req_idle", {31'h0, imem_req}, 32'h0);
    check("t2_grants", addr_log.size(), 32'd2);
    check("t2_valid", {31'h0, instr_valid}, 32'h1);
    check("t2_head_pc", instr_pc, 32'h0);
    check("t2_head_ins", instruction, 32'h0050_0093);
    instr_ready = 1'b1; tick; instr_ready = 1'b0;
    check("t2_next_pc", instr_pc, 32'h4);
    wait_req;
    check("t2_addr8", imem_addr, 32'h8);

    // 3: redirect while waiting for 0x8; late response must be discarded.
    do_reset;
    imem_gnt = 1'b1; instr_ready = 1'b1; stall_en = 1'b1; stall_addr = 32'h8;
    for (int i = 0; i < 30 && addr_log.size() < 3; i++) tick;
    check("t3_grant8", {31'h0, addr_log.size() >= 3}, 32'h1);
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick;
    redirect_valid = 1'b0; pop_log.delete();
    check("t3_drop_req", {31'h0, imem_req}, 32'h0);
    check("t3_flushed", {31'h0, instr_valid}, 32'h0);
    tick; tick;
    check("t3_drop_hold", {31'h0, imem_req}, 32'h0);
    rvalid_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    tick;
    rvalid_man = 1'b0;
    check("t3_req", {31'h0, imem_req}, 32'h1);
    check("t3_addr", imem_addr, 32'h100);
    stall_en = 1'b0; imem_gnt = 1'b1;
    wait_pops(1);
    check("t3_pop_pc", pop_log[0][63:32], 32'h100);
    check("t3_pop_ins", pop_log[0][31:0], mem_word(32'h100));

    // 4: redirect coincides with the grant for 0x8 while the buffer holds data.
    do_reset;
    imem_gnt = 1'b1;
    repeat (10) tick;
    imem_gnt = 1'b0;
    check("t4_full_pc", instr_pc, 32'h0);
    instr_ready = 1'b1; tick; instr_ready = 1'b0;
    wait_req;
    check("t4_addr8", imem_addr, 32'h8);
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick;
    redirect_valid = 1'b0; imem_gnt = 1'b0; pop_log.delete();
    check("t4_flushed", {31'h0, instr_valid}, 32'h0);
    check("t4_drop_req", {31'h0, imem_req}, 32'h0);
    tick;
    check("t4_req", {31'h0, imem_req}, 32'h1);
    check("t4_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1; instr_ready = 1'b1;
    wait_pops(1);
    check("t4_pop_pc", pop_log[0][63:32], 32'h100);

    // 5: unaligned redirect target and PC wrap at the top of the address space.
    do_reset;
    instr_ready = 1'b1;
    wait_req;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick;
    redirect_valid = 1'b0;
    check("t5_req", {31'h0, imem_req}, 32'h1);
    check("t5_align", imem_addr, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0; addr_log.delete(); pop_log.delete();
    check("t5_top", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    for (int i = 0; i < 30 && addr_log.size() < 2; i++) tick;
    check("t5_grants", {31'h0, addr_log.size() >= 2}, 32'h1);
    check("t5_addr0", addr_log[0], 32'hFFFF_FFFC);
    check("t5_addr1", addr_log[1], 32'h0);
    wait_pops(2);
    check("t5_pop0_pc", pop_log[0][63:32], 32'hFFFF_FFFC);
    check("t5_pop1_pc", pop_log[1][63:32], 32'h0);
    check("t5_pop1_ins", pop_log[1][31:0], 32'h0050_0093);

    // 6: reset during WAIT, then a stale response arrives.
    do_reset;
    imem_gnt = 1'b1; stall_en = 1'b1; stall_addr = 32'h0;
    for (int i = 0; i < 20 && addr_log.size() < 1; i++) tick;
    check("t6_grant", {31'h0, addr_log.size() >= 1}, 32'h1);
    imem_gnt = 1'b0; rst_n = 1'b0;
    tick;
    check_reset_outputs("t6_rst");
    rst_n = 1'b1; rvalid_man = 1'b1; rdata_man = 32'h1234_5678;
    tick;
    rvalid_man = 1'b0;
    check("t6_stale", {31'h0, instr_valid}, 32'h0);
    check("t6_req", {31'h0, imem_req}, 32'h1);
    check("t6_addr", imem_addr, 32'h0);
    stall_en = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1; pop_log.delete();
    wait_pops(1);
    check("t6_pop_pc", pop_log[0][63:32], 32'h0);
    check("t6_pop_ins", pop_log[0][31:0], 32'h0050_0093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
